// File: rtl/sp_ram_arbiter_pkg.sv
// Shared memory-library definitions: arbiter FSM encoding and requester count.
package sp_ram_arbiter_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sp_ram_arbiter_model.sv
// Single-port synchronous RAM with per-bit write mask and registered read data.
module sp_ram_model #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  ce,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] bw,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Unreset storage; a write merges masked bits, a read returns data next cycle.
   always_ff @(posedge clk) begin
      if (ce) begin
         if (we) begin
            mem[addr] <= (wdata & bw) | (mem[addr] & ~bw);
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin front end for a single-port RAM, with a post-reset clear sweep.
module sp_ram_arbiter
   import sp_ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   output logic                          INIT_DONE,
   input  logic [NUM_REQ-1:0]            REQ_VALID,
   output logic [NUM_REQ-1:0]            REQ_READY,
   input  logic [NUM_REQ-1:0]            REQ_WE,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_BW,
   output logic [NUM_REQ-1:0]            RSP_VALID,
   output logic [DATA_WIDTH-1:0]         RSP_DATA
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   arb_state_t            state, state_next;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  prio;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    rsp_q;
   logic                  sel;
   logic                  ram_ce, ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata, ram_bw, ram_rdata;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= INIT;
         cnt   <= '0;
         prio  <= 1'b0;
         rsp_q <= '0;
      end else begin
         state <= state_next;
         if (state == INIT && cnt != LAST_ADDR) begin
            cnt <= cnt + 1'b1;
         end
         // prio names the requester that wins a tie next time
         if (|grant) begin
            prio <= grant[0];
         end
         rsp_q <= grant & ~REQ_WE;
      end
   end

   always_comb begin
      state_next = state;
      grant      = '0;
      sel        = 1'b0;
      ram_ce     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
      ram_bw     = '0;
      case (state)
         INIT: begin
            ram_ce   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = cnt;
            ram_bw   = '1;
            if (cnt == LAST_ADDR) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (&REQ_VALID) begin
               grant = prio ? 2'b10 : 2'b01;
            end else begin
               grant = REQ_VALID;
            end
            sel       = grant[1];
            ram_ce    = |grant;
            ram_we    = sel ? REQ_WE[1] : REQ_WE[0];
            ram_addr  = sel ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
            ram_wdata = sel ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
            ram_bw    = sel ? REQ_BW[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_BW[DATA_WIDTH-1:0];
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   sp_ram_model #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_ram (
      .clk  (CLK),
      .ce   (ram_ce),
      .we   (ram_we),
      .addr (ram_addr),
      .wdata(ram_wdata),
      .bw   (ram_bw),
      .rdata(ram_rdata)
   );

   assign REQ_READY = grant;
   assign INIT_DONE = (state == RUN);
   // A response in flight is suppressed as soon as reset is driven low
   assign RSP_VALID = rsp_q & {NUM_REQ{RST_N}};
   assign RSP_DATA  = ram_rdata;

endmodule
